y86_alu: RTL and testbench

64-bit two-operand arithmetic/logic unit for the Y86-64 sequential processor's execute stage. It computes AND, XOR, ADD or SUB on two signed 64-bit operands selected by a 2-bit opcode. It registers the result, the carry-out and the Z/S/O condition flags once per clock. The execute stage feeds it `valA`/`valB` for OPq instructions and latches the flags into its condition-code logic.

---
 rtl/y86_pkg.sv | 13 +
 rtl/adder64.sv | 24 ++
 rtl/y86_alu.sv | 90 +++++++++
 tb/tb_y86_alu.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared ALU width and operation encodings for the Y86-64 execute stage
package y86_pkg;

  localparam int WIDTH = 64;

  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_XOR = 2'b01,
    ALU_ADD = 2'b10,
    ALU_SUB = 2'b11
  } alu_op_e;

endpackage

// File: rtl/adder64.sv
// rtl/adder64.sv - ripple-carry adder built from full-adder bit cells
module adder64 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // carry[i] is the carry into bit cell i; carry[WIDTH] leaves the MSB
  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/y86_alu.sv
// rtl/y86_alu.sv - registered AND/XOR/ADD/SUB unit with carry and Z/S/O flags
module y86_alu
  import y86_pkg::*;
#(
  parameter int WIDTH = y86_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] Q,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] Z,
  output logic             carryout,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int MSB = WIDTH - 1;

  logic             is_sub;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  logic [WIDTH-1:0] z_d, z_q;
  logic             carry_d, carry_q;
  logic             zf_d, zf_q;
  logic             sf_d, sf_q;
  logic             of_d, of_q;

  // SUB reuses the adder as P + ~Q + 1
  assign is_sub = (select == ALU_SUB);
  assign add_b  = is_sub ? ~Q : Q;

  adder64 #(.WIDTH(WIDTH)) u_adder (
    .a    (P),
    .b    (add_b),
    .cin  (is_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // result mux and flag generation for the operation currently on the inputs
  always_comb begin
    z_d     = '0;
    carry_d = 1'b0;
    of_d    = 1'b0;
    case (select)
      ALU_AND: z_d = P & Q;
      ALU_XOR: z_d = P ^ Q;
      ALU_ADD: begin
        z_d     = add_sum;
        carry_d = add_cout;
        of_d    = (P[MSB] == Q[MSB]) && (add_sum[MSB] != P[MSB]);
      end
      default: begin
        z_d     = add_sum;
        carry_d = add_cout;
        of_d    = (P[MSB] != Q[MSB]) && (add_sum[MSB] != P[MSB]);
      end
    endcase
    zf_d = (z_d == '0);
    sf_d = z_d[MSB];
  end

  // output register bank: result and flags always captured together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q     <= '0;
      carry_q <= 1'b0;
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      z_q     <= z_d;
      carry_q <= carry_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      of_q    <= of_d;
    end
  end

  assign Z        = z_q;
  assign carryout = carry_q;
  assign zf       = zf_q;
  assign sf       = sf_q;
  assign of       = of_q;

endmodule

// File: tb/tb_y86_alu.sv
// tb/tb_y86_alu.sv - vector table plus scoreboard bench for y86_alu
module tb_y86_alu;
  import y86_pkg::*;

  localparam int W = 64;
  localparam logic [W-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [W-1:0] z;
    logic         c;
    logic         zf;
    logic         sf;
    logic         of;
  } res_t;

  typedef struct packed {
    logic [W-1:0] p;
    logic [W-1:0] q;
    logic [1:0]   sel;
    res_t         exp;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] P;
  logic [W-1:0] Q;
  logic [1:0]   select;
  logic [W-1:0] Z;
  logic         carryout, zf, sf, of;

  int   n_vec;
  int   n_miss;
  res_t sb[$];
  res_t last_exp;
  vec_t tbl[10];

  y86_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .P        (P),
    .Q        (Q),
    .select   (select),
    .Z        (Z),
    .carryout (carryout),
    .zf       (zf),
    .sf       (sf),
    .of       (of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  // independent reference: wide signed arithmetic for overflow, unsigned compare for borrow
  function automatic res_t model(input logic [W-1:0] p, input logic [W-1:0] q, input logic [1:0] s);
    res_t r;
    logic [W:0] wu;
    logic signed [W:0] ws;
    r = '0;
    case (s)
      2'b00: r.z = p & q;
      2'b01: r.z = p ^ q;
      2'b10: begin
        wu   = {1'b0, p} + {1'b0, q};
        ws   = $signed({p[W-1], p}) + $signed({q[W-1], q});
        r.z  = wu[W-1:0];
        r.c  = wu[W];
        r.of = ws[W] != ws[W-1];
      end
      default: begin
        ws   = $signed({p[W-1], p}) - $signed({q[W-1], q});
        r.z  = p - q;
        r.c  = (p >= q);
        r.of = ws[W] != ws[W-1];
      end
    endcase
    r.zf = (r.z == '0);
    r.sf = r.z[W-1];
    return r;
  endfunction

  function automatic res_t got();
    return {Z, carryout, zf, sf, of};
  endfunction

  task automatic cmp(input string name, input res_t e);
    res_t g;
    g = got();
    n_vec++;
    if (g !== e) begin
      n_miss++;
      $display("FAIL %s: got Z=%h c=%b zf=%b sf=%b of=%b, required Z=%h c=%b zf=%b sf=%b of=%b",
               name, g.z, g.c, g.zf, g.sf, g.of, e.z, e.c, e.zf, e.sf, e.of);
    end
  endtask

  task automatic drive(input logic [W-1:0] p, input logic [W-1:0] q, input logic [1:0] s, input res_t e);
    @(negedge clk);
    P      = p;
    Q      = q;
    select = s;
    sb.push_back(e);
  endtask

  task automatic check_out(input string name);
    res_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: scoreboard empty, required a pending expectation", name);
    end else begin
      e = sb.pop_front();
      cmp(name, e);
      last_exp = e;
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    P      = '0;
    Q      = '0;
    select = ALU_AND;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    #2 cmp("reset_state", '0);

    tbl[0] = '{MAXP,      64'd1,     ALU_ADD, '{MINN,        1'b0, 1'b0, 1'b1, 1'b1}};
    tbl[1] = '{ONES,      64'd1,     ALU_ADD, '{64'd0,       1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[2] = '{64'd3,     64'd5,     ALU_SUB, '{64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0}};
    tbl[3] = '{64'd5,     64'd5,     ALU_SUB, '{64'd0,       1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[4] = '{64'hF0F0,  64'hFF00,  ALU_AND, '{64'hF000,    1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[5] = '{64'hF0F0,  64'hFF00,  ALU_XOR, '{64'h0FF0,    1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[6] = '{MINN,      MINN,      ALU_SUB, '{64'd0,       1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[7] = '{MINN,      MINN,      ALU_ADD, '{64'd0,       1'b1, 1'b1, 1'b0, 1'b1}};
    tbl[8] = '{64'd0,     MINN,      ALU_SUB, '{MINN,        1'b0, 1'b0, 1'b1, 1'b1}};
    tbl[9] = '{ONES,      ONES,      ALU_AND, '{ONES,        1'b0, 1'b0, 1'b1, 1'b0}};

    // release reset with ADD 5+3 waiting: first edge captures it
    @(negedge clk);
    P = 64'd5; Q = 64'd3; select = ALU_ADD;
    rst_n = 1'b1;
    sb.push_back('{64'd8, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1 check_out("release_add8");

    // table vectors, back to back
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].p, tbl[i].q, tbl[i].sel, tbl[i].exp);
      @(posedge clk); #1 check_out($sformatf("table_%0d", i));
    end

    // random vectors against the model
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] rp, rq;
      logic [1:0]   rs;
      rp = {$urandom, $urandom};
      rq = {$urandom, $urandom};
      if (i % 4 == 3) rq = rp;
      rs = 2'($urandom_range(0, 3));
      drive(rp, rq, rs, model(rp, rq, rs));
      @(posedge clk); #1 check_out($sformatf("random_%0d", i));
    end

    // pipelining: select steps every cycle, outputs must lag inputs by exactly one edge
    for (int i = 0; i < 4; i++) begin
      drive(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 2'(i),
            model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 2'(i)));
      #3 cmp($sformatf("pipe_hold_%0d", i), last_exp);
      @(posedge clk); #1 check_out($sformatf("pipe_%0d", i));
    end

    // mid-stream reset: pending operation discarded, outputs clear without a clock edge
    drive(64'd5, 64'd3, ALU_ADD, '{64'd8, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1 check_out("pre_reset_add8");
    @(negedge clk);
    P = 64'd7; Q = 64'd9; select = ALU_XOR;
    #2 rst_n = 1'b0;
    #1 cmp("async_clear", '0);
    @(posedge clk); #1 cmp("reset_hold", '0);
    @(negedge clk);
    P = 64'd5; Q = 64'd3; select = ALU_ADD;
    rst_n = 1'b1;
    sb.push_back('{64'd8, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1 check_out("post_reset_add8");

    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
